// File: rtl/apb_to_ahbl_pkg.sv
// Shared encodings for the APB-to-AHB-Lite bridge: FSM states, HTRANS/HSIZE codes
// and the tied AHB attribute values.
package apb_to_ahbl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    localparam logic [2:0] HSIZE_BYTE = 3'b000;
    localparam logic [2:0] HSIZE_HALF = 3'b001;
    localparam logic [2:0] HSIZE_WORD = 3'b010;

    localparam logic [3:0] HPROT_TIED    = 4'b0011;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;

endpackage

// File: rtl/apb_to_ahbl_if.sv
// Bus bundle for apb_to_ahbl: APB completer side plus AHB-Lite master side.
// apbs_pstrb exists only when APB_TO_AHBL_PSTRB_EN is defined.
interface apb_to_ahbl_if #(
    parameter int W_HADDR = 32,
    parameter int W_PADDR = 16,
    parameter int W_DATA  = 32
);
    logic               apbs_psel;
    logic               apbs_penable;
    logic               apbs_pwrite;
    logic [W_PADDR-1:0] apbs_paddr;
    logic [W_DATA-1:0]  apbs_pwdata;
`ifdef APB_TO_AHBL_PSTRB_EN
    logic [3:0]         apbs_pstrb;
`endif
    logic [W_DATA-1:0]  apbs_prdata;
    logic               apbs_pready;
    logic               apbs_pslverr;

    logic [W_HADDR-1:0] ahblm_haddr;
    logic               ahblm_hwrite;
    logic [1:0]         ahblm_htrans;
    logic [2:0]         ahblm_hsize;
    logic [2:0]         ahblm_hburst;
    logic [3:0]         ahblm_hprot;
    logic               ahblm_hmastlock;
    logic [W_DATA-1:0]  ahblm_hwdata;
    logic               ahblm_hready;
    logic               ahblm_hresp;
    logic [W_DATA-1:0]  ahblm_hrdata;

    // Bridge view: APB completer, AHB-Lite master.
    modport slave (
`ifdef APB_TO_AHBL_PSTRB_EN
        input  apbs_pstrb,
`endif
        input  apbs_psel, apbs_penable, apbs_pwrite, apbs_paddr, apbs_pwdata,
        output apbs_prdata, apbs_pready, apbs_pslverr,
        output ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst,
        output ahblm_hprot, ahblm_hmastlock, ahblm_hwdata,
        input  ahblm_hready, ahblm_hresp, ahblm_hrdata
    );

    // Environment view: APB requester, AHB-Lite fabric.
    modport master (
`ifdef APB_TO_AHBL_PSTRB_EN
        output apbs_pstrb,
`endif
        output apbs_psel, apbs_penable, apbs_pwrite, apbs_paddr, apbs_pwdata,
        input  apbs_prdata, apbs_pready, apbs_pslverr,
        input  ahblm_haddr, ahblm_hwrite, ahblm_htrans, ahblm_hsize, ahblm_hburst,
        input  ahblm_hprot, ahblm_hmastlock, ahblm_hwdata,
        output ahblm_hready, ahblm_hresp, ahblm_hrdata
    );

endinterface

// File: rtl/apb_pstrb_decode.sv
// Maps an APB write strobe to AHB size and byte-lane offset; only built with
// APB_TO_AHBL_PSTRB_EN, since nothing else instantiates it.
`ifdef APB_TO_AHBL_PSTRB_EN
module apb_pstrb_decode
    import apb_to_ahbl_pkg::*;
(
    input  logic [3:0] pstrb,
    output logic [2:0] hsize,
    output logic [1:0] offset,
    output logic       valid
);

    always_comb begin
        hsize  = HSIZE_WORD;
        offset = 2'd0;
        valid  = 1'b1;
        case (pstrb)
            4'b0001: begin hsize = HSIZE_BYTE; offset = 2'd0; end
            4'b0010: begin hsize = HSIZE_BYTE; offset = 2'd1; end
            4'b0100: begin hsize = HSIZE_BYTE; offset = 2'd2; end
            4'b1000: begin hsize = HSIZE_BYTE; offset = 2'd3; end
            4'b0011: begin hsize = HSIZE_HALF; offset = 2'd0; end
            4'b1100: begin hsize = HSIZE_HALF; offset = 2'd2; end
            4'b1111: begin hsize = HSIZE_WORD; offset = 2'd0; end
            default: valid = 1'b0;
        endcase
    end

endmodule
`endif

// File: rtl/apb_to_ahbl.sv
// APB completer issuing one AHB-Lite SINGLE transfer per APB access.
// Optional byte/halfword writes from pstrb when APB_TO_AHBL_PSTRB_EN is defined.
//
// state | meaning
// IDLE  | waiting for APB setup phase
// ADDR  | AHB address phase, NONSEQ driven until hready
// DATA  | AHB data phase, hwdata held until hready
// RESP  | one-cycle APB completion (pready)
module apb_to_ahbl
    import apb_to_ahbl_pkg::*;
#(
    parameter int                 W_HADDR    = 32,
    parameter int                 W_PADDR    = 16,
    parameter int                 W_DATA     = 32,
    parameter logic [W_HADDR-1:0] HADDR_BASE = '0
) (
    input  logic           clk,
    input  logic           rst,
    apb_to_ahbl_if.slave   bus
);

    state_t             state;
    state_t             state_nxt;
    logic [W_HADDR-1:0] haddr_r;
    logic               hwrite_r;
    logic [2:0]         hsize_r;
    logic [W_DATA-1:0]  hwdata_r;
    logic [W_DATA-1:0]  prdata_r;
    logic               pslverr_r;

    logic               setup;
    logic [2:0]         req_hsize;
    logic [1:0]         req_ofs;
    logic               req_ok;
    logic [W_HADDR-1:0] req_haddr;
    logic [1:0]         htrans_c;
    logic               pready_c;

    assign setup = bus.apbs_psel & ~bus.apbs_penable;

`ifdef APB_TO_AHBL_PSTRB_EN
    logic [2:0] dec_hsize;
    logic [1:0] dec_ofs;
    logic       dec_valid;

    apb_pstrb_decode u_pstrb_decode (
        .pstrb  (bus.apbs_pstrb),
        .hsize  (dec_hsize),
        .offset (dec_ofs),
        .valid  (dec_valid)
    );

    // Reads ignore the strobe and are always word accesses.
    always_comb begin
        req_hsize = HSIZE_WORD;
        req_ofs   = 2'd0;
        req_ok    = 1'b1;
        if (bus.apbs_pwrite) begin
            req_hsize = dec_hsize;
            req_ofs   = dec_ofs;
            req_ok    = dec_valid;
        end
    end
`else
    assign req_hsize = HSIZE_WORD;
    assign req_ofs   = 2'd0;
    assign req_ok    = 1'b1;
`endif

    // Word-align first, then place the lane offset.
    always_comb begin
        req_haddr      = HADDR_BASE | W_HADDR'(bus.apbs_paddr);
        req_haddr[1:0] = req_ofs;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        htrans_c  = HTRANS_IDLE;
        pready_c  = 1'b0;
        case (state)
            ST_IDLE: if (setup) state_nxt = req_ok ? ST_ADDR : ST_RESP;
            ST_ADDR: begin
                htrans_c = HTRANS_NONSEQ;
                if (bus.ahblm_hready) state_nxt = ST_DATA;
            end
            ST_DATA: if (bus.ahblm_hready) state_nxt = ST_RESP;
            ST_RESP: begin
                pready_c  = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // hresp is only trusted on the hready=1 cycle of the two-cycle error.
    always_ff @(posedge clk) begin
        if (rst) begin
            haddr_r   <= '0;
            hwrite_r  <= 1'b0;
            hsize_r   <= HSIZE_WORD;
            hwdata_r  <= '0;
            prdata_r  <= '0;
            pslverr_r <= 1'b0;
        end else begin
            if (state == ST_IDLE && setup) begin
                haddr_r   <= req_haddr;
                hwrite_r  <= bus.apbs_pwrite;
                hsize_r   <= req_hsize;
                hwdata_r  <= bus.apbs_pwdata;
                pslverr_r <= ~req_ok;
            end
            if (state == ST_DATA && bus.ahblm_hready) begin
                pslverr_r <= bus.ahblm_hresp;
                if (!hwrite_r) prdata_r <= bus.ahblm_hrdata;
            end
        end
    end

    assign bus.apbs_prdata     = prdata_r;
    assign bus.apbs_pready     = pready_c;
    assign bus.apbs_pslverr    = pready_c & pslverr_r;

    assign bus.ahblm_haddr     = haddr_r;
    assign bus.ahblm_hwrite    = hwrite_r;
    assign bus.ahblm_htrans    = htrans_c;
    assign bus.ahblm_hsize     = hsize_r;
    assign bus.ahblm_hburst    = HBURST_SINGLE;
    assign bus.ahblm_hprot     = HPROT_TIED;
    assign bus.ahblm_hmastlock = 1'b0;
    assign bus.ahblm_hwdata    = hwdata_r;

endmodule

// File: tb/tb_apb_to_ahbl.sv
// Bench for apb_to_ahbl: directed cases then random APB accesses against a
// per-transaction timeline model; builds with or without APB_TO_AHBL_PSTRB_EN.
module tb_apb_to_ahbl;

    localparam logic [31:0] BASE = 32'h2000_0000;
`ifdef APB_TO_AHBL_PSTRB_EN
    localparam bit PSTRB_EN = 1'b1;
`else
    localparam bit PSTRB_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    apb_to_ahbl_if #(.W_HADDR(32), .W_PADDR(16), .W_DATA(32)) bus_if ();

    apb_to_ahbl #(
        .W_HADDR    (32),
        .W_PADDR    (16),
        .W_DATA     (32),
        .HADDR_BASE (BASE)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] mdl_prdata = 32'h0;

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %h, expected %h", tag, $time, obs, exp);
        end
    endtask

    // Expected size/offset/acceptance from the strobe rules.
    task automatic expect_strb(input logic wr, input logic [3:0] strb,
                               output logic [2:0] sz, output logic [1:0] ofs, output bit ok);
        sz = 3'd2; ofs = 2'd0; ok = 1'b1;
        if (PSTRB_EN && wr) begin
            if (strb == 4'hF) begin
                sz = 3'd2;
            end else if ($countones(strb) == 1) begin
                sz = 3'd0;
                for (int b = 0; b < 4; b++) if (strb[b]) ofs = 2'(b);
            end else if (strb == 4'b0011 || strb == 4'b1100) begin
                sz  = 3'd1;
                ofs = strb[2] ? 2'd2 : 2'd0;
            end else begin
                ok = 1'b0;
            end
        end
    endtask

    task automatic bus_idle();
        bus_if.apbs_psel    = 1'b0;
        bus_if.apbs_penable = 1'b0;
        bus_if.ahblm_hready = 1'b1;
        bus_if.ahblm_hresp  = 1'b0;
        bus_if.ahblm_hrdata = $urandom;
    endtask

    // One APB access; wa/wd are AHB wait states in address/data phase.
    task automatic run_xfer(input logic wr, input logic [15:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input int wa, input int wd_in,
                            input bit err, input logic [31:0] rdata);
        int          wd;
        logic [2:0]  e_size;
        logic [1:0]  e_ofs;
        bit          ok;
        logic [31:0] e_haddr;
        wd = (err && wd_in == 0) ? 1 : wd_in;
        expect_strb(wr, strb, e_size, e_ofs, ok);
        e_haddr = ((BASE | {16'h0, addr}) & 32'hFFFF_FFFC) | {30'h0, e_ofs};

        @(negedge clk);
        chk_eq("idle_pready", bus_if.apbs_pready, 0);
        bus_if.apbs_psel    = 1'b1;
        bus_if.apbs_penable = 1'b0;
        bus_if.apbs_pwrite  = wr;
        bus_if.apbs_paddr   = addr;
        bus_if.apbs_pwdata  = wdata;
`ifdef APB_TO_AHBL_PSTRB_EN
        bus_if.apbs_pstrb   = strb;
`endif
        bus_if.ahblm_hready = 1'b1;
        bus_if.ahblm_hresp  = 1'b0;

        @(negedge clk);
        bus_if.apbs_penable = 1'b1;
        if (!ok) begin
            chk_eq("bad_strb_pready", bus_if.apbs_pready, 1);
            chk_eq("bad_strb_pslverr", bus_if.apbs_pslverr, 1);
            chk_eq("bad_strb_htrans", bus_if.ahblm_htrans, 0);
            chk_eq("bad_strb_prdata", bus_if.apbs_prdata, mdl_prdata);
            return;
        end
        for (int i = 0; i <= wa; i++) begin
            if (i > 0) @(negedge clk);
            chk_eq("addr_htrans", bus_if.ahblm_htrans, 32'h2);
            chk_eq("addr_haddr", bus_if.ahblm_haddr, e_haddr);
            chk_eq("addr_hwrite", bus_if.ahblm_hwrite, wr);
            chk_eq("addr_hsize", bus_if.ahblm_hsize, e_size);
            chk_eq("addr_pready", bus_if.apbs_pready, 0);
            bus_if.ahblm_hready = (i == wa);
            bus_if.ahblm_hrdata = $urandom;
        end
        for (int j = 0; j <= wd; j++) begin
            @(negedge clk);
            chk_eq("data_htrans", bus_if.ahblm_htrans, 0);
            chk_eq("data_pready", bus_if.apbs_pready, 0);
            if (wr) chk_eq("data_hwdata", bus_if.ahblm_hwdata, wdata);
            bus_if.ahblm_hready = (j == wd);
            bus_if.ahblm_hresp  = err && (j >= wd - 1);
            bus_if.ahblm_hrdata = (j == wd) ? rdata : $urandom;
        end
        @(negedge clk);
        bus_if.ahblm_hready = 1'b1;
        bus_if.ahblm_hresp  = 1'b0;
        if (!wr) mdl_prdata = rdata;
        chk_eq("resp_pready", bus_if.apbs_pready, 1);
        chk_eq("resp_pslverr", bus_if.apbs_pslverr, err);
        chk_eq("resp_prdata", bus_if.apbs_prdata, mdl_prdata);
    endtask

    initial begin
        bus_if.apbs_pwrite = 1'b0;
        bus_if.apbs_paddr  = '0;
        bus_if.apbs_pwdata = '0;
`ifdef APB_TO_AHBL_PSTRB_EN
        bus_if.apbs_pstrb  = 4'hF;
`endif
        bus_idle();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk_eq("rst_htrans", bus_if.ahblm_htrans, 0);
        chk_eq("rst_haddr", bus_if.ahblm_haddr, 0);
        chk_eq("rst_hwrite", bus_if.ahblm_hwrite, 0);
        chk_eq("rst_hsize", bus_if.ahblm_hsize, 32'h2);
        chk_eq("rst_hwdata", bus_if.ahblm_hwdata, 0);
        chk_eq("rst_prdata", bus_if.apbs_prdata, 0);
        chk_eq("rst_pready", bus_if.apbs_pready, 0);
        chk_eq("rst_pslverr", bus_if.apbs_pslverr, 0);
        chk_eq("tie_hburst", bus_if.ahblm_hburst, 0);
        chk_eq("tie_hprot", bus_if.ahblm_hprot, 32'h3);
        chk_eq("tie_hmastlock", bus_if.ahblm_hmastlock, 0);
        rst = 1'b0;

        run_xfer(1'b0, 16'h0040, 32'h0, 4'hF, 0, 0, 1'b0, 32'hCAFE_F00D);
        run_xfer(1'b1, 16'h0044, 32'h1234_5678, 4'hF, 0, 2, 1'b0, 32'h0);
        run_xfer(1'b0, 16'h0048, 32'h0, 4'hF, 0, 1, 1'b1, 32'hDEAD_0001);
        run_xfer(1'b0, 16'h004C, 32'h0, 4'hF, 1, 0, 1'b0, 32'h0BAD_BEEF);
        if (PSTRB_EN) begin
            run_xfer(1'b1, 16'h0010, 32'hAABB_CCDD, 4'b1100, 0, 0, 1'b0, 32'h0);
            run_xfer(1'b1, 16'h0010, 32'hAABB_CCDD, 4'b0101, 0, 0, 1'b0, 32'h0);
            run_xfer(1'b1, 16'h0013, 32'h0000_0077, 4'b1000, 0, 0, 1'b0, 32'h0);
            run_xfer(1'b1, 16'h0020, 32'h0, 4'b0000, 0, 0, 1'b0, 32'h0);
        end

        // Reset while the AHB data phase is stalled.
        @(negedge clk);
        bus_idle();
        bus_if.apbs_psel    = 1'b1;
        bus_if.apbs_pwrite  = 1'b0;
        bus_if.apbs_paddr   = 16'h0080;
        @(negedge clk);
        bus_if.apbs_penable = 1'b1;
        @(negedge clk);
        chk_eq("rstmid_in_data", bus_if.ahblm_htrans, 0);
        bus_if.ahblm_hready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        mdl_prdata = 32'h0;
        chk_eq("rstmid_htrans", bus_if.ahblm_htrans, 0);
        chk_eq("rstmid_pready", bus_if.apbs_pready, 0);
        chk_eq("rstmid_prdata", bus_if.apbs_prdata, 0);
        chk_eq("rstmid_haddr", bus_if.ahblm_haddr, 0);
        bus_idle();
        @(negedge clk);
        chk_eq("rstmid_stay_idle", bus_if.apbs_pready, 0);
        run_xfer(1'b0, 16'h0084, 32'h0, 4'hF, 0, 0, 1'b0, 32'h5555_AAAA);

        // Back-to-back reads with setup right after RESP.
        run_xfer(1'b0, 16'h0100, 32'h0, 4'hF, 0, 0, 1'b0, 32'h1111_1111);
        run_xfer(1'b0, 16'h0104, 32'h0, 4'hF, 0, 0, 1'b0, 32'h2222_2222);
        run_xfer(1'b0, 16'h0108, 32'h0, 4'hF, 0, 0, 1'b0, 32'h3333_3333);

        for (int t = 0; t < 60; t++) begin
            logic       wr;
            logic [3:0] strb;
            int         gap;
            wr   = 1'($urandom_range(0, 1));
            strb = (wr && $urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hF;
            gap  = $urandom_range(0, 2);
            if (gap > 0) begin
                @(negedge clk);
                bus_idle();
                repeat (gap - 1) @(negedge clk);
            end
            run_xfer(wr, 16'($urandom), $urandom, strb, $urandom_range(0, 2),
                     $urandom_range(0, 3), ($urandom_range(0, 4) == 0), $urandom);
        end

        @(negedge clk);
        bus_idle();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
